// File: rtl/crtc_timing.sv
// crtc_timing: 6845-class CRTC producing HSYNC/VSYNC, display enable, memory and raster address
// on the character-clock enable, with a select/write register port.
module crtc_timing (
    input  logic        clk,
    input  logic        reset,
    input  logic        cclk_en,
    input  logic        cs,
    input  logic        rs,
    input  logic        wr,
    input  logic [7:0]  din,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        DE,
    output logic [13:0] MA,
    output logic [4:0]  RA
);
    typedef enum logic {NORMAL, ADJUST} state_t;

    logic [4:0]  addr_q;
    logic [7:0]  r0_q, r1_q, r2_q, r3_q, r13_q;
    logic [6:0]  r4_q, r6_q, r7_q;
    logic [4:0]  r5_q, r9_q;
    logic [5:0]  r12_q;

    state_t      state_q, state_d;
    logic [7:0]  hcc_q, hcc_d;
    logic [4:0]  rcc_q, rcc_d, vac_q, vac_d;
    logic [6:0]  vcc_q, vcc_d;
    logic [13:0] ma_row_q, ma_row_d, ma_next_q, ma_next_d;
    logic        hdisp_q, hdisp_d, vdisp_q, vdisp_d, vs_q, vs_d;
    logic [3:0]  hsw_q, hsw_d, vcnt_q, vcnt_d;
    logic        hsync_d, vsync_d, de_d;
    logic [13:0] ma_d;
    logic        line_end, row_last, row_start, frame_start;
    logic        hs_start, vs_start, vs_now, hdisp_now, vdisp_now;
    logic [3:0]  vcnt_cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            r0_q   <= '0;
            r1_q   <= '0;
            r2_q   <= '0;
            r3_q   <= '0;
            r4_q   <= '0;
            r5_q   <= '0;
            r6_q   <= '0;
            r7_q   <= '0;
            r9_q   <= '0;
            r12_q  <= '0;
            r13_q  <= '0;
        end else if (cs && wr) begin
            if (!rs) addr_q <= din[4:0];
            else begin
                case (addr_q)
                    5'd0:  r0_q  <= din;
                    5'd1:  r1_q  <= din;
                    5'd2:  r2_q  <= din;
                    5'd3:  r3_q  <= din;
                    5'd4:  r4_q  <= din[6:0];
                    5'd5:  r5_q  <= din[4:0];
                    5'd6:  r6_q  <= din[6:0];
                    5'd7:  r7_q  <= din[6:0];
                    5'd9:  r9_q  <= din[4:0];
                    5'd12: r12_q <= din[5:0];
                    5'd13: r13_q <= din;
                    default: ;
                endcase
            end
        end
    end

    // Counters hold the character shown at the next enable; vdisp starts set so a fresh run opens a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= NORMAL;
            hcc_q     <= '0;
            rcc_q     <= '0;
            vcc_q     <= '0;
            vac_q     <= '0;
            ma_row_q  <= '0;
            ma_next_q <= '0;
            hdisp_q   <= 1'b0;
            vdisp_q   <= 1'b1;
            vs_q      <= 1'b0;
            hsw_q     <= '0;
            vcnt_q    <= '0;
            HSYNC     <= 1'b0;
            VSYNC     <= 1'b0;
            DE        <= 1'b0;
            MA        <= '0;
            RA        <= '0;
        end else if (cclk_en) begin
            state_q   <= state_d;
            hcc_q     <= hcc_d;
            rcc_q     <= rcc_d;
            vcc_q     <= vcc_d;
            vac_q     <= vac_d;
            ma_row_q  <= ma_row_d;
            ma_next_q <= ma_next_d;
            hdisp_q   <= hdisp_d;
            vdisp_q   <= vdisp_d;
            vs_q      <= vs_d;
            hsw_q     <= hsw_d;
            vcnt_q    <= vcnt_d;
            HSYNC     <= hsync_d;
            VSYNC     <= vsync_d;
            DE        <= de_d;
            MA        <= ma_d;
            RA        <= rcc_q;
        end
    end

    always_comb begin
        line_end    = hcc_q == r0_q;
        row_last    = rcc_q == r9_q;
        hcc_d       = line_end ? 8'd0 : hcc_q + 8'd1;
        ma_next_d   = (hcc_q == r1_q && row_last) ? ma_row_q + 14'(r1_q) : ma_next_q;
        state_d     = state_q;
        rcc_d       = rcc_q;
        vcc_d       = vcc_q;
        vac_d       = vac_q;
        ma_row_d    = ma_row_q;
        frame_start = 1'b0;
        if (line_end) begin
            if (state_q == ADJUST) begin
                if (vac_q == r5_q - 5'd1) frame_start = 1'b1;
                else begin
                    vac_d = vac_q + 5'd1;
                    rcc_d = rcc_q + 5'd1;
                end
            end else if (!row_last) rcc_d = rcc_q + 5'd1;
            else if (vcc_q != r4_q) begin
                rcc_d    = '0;
                vcc_d    = vcc_q + 7'd1;
                ma_row_d = ma_next_d;
            end else if (r5_q == '0) frame_start = 1'b1;
            else begin
                state_d  = ADJUST;
                vac_d    = '0;
                rcc_d    = rcc_q + 5'd1;
                ma_row_d = ma_next_d;
            end
        end
        if (frame_start) begin
            state_d  = NORMAL;
            rcc_d    = '0;
            vcc_d    = '0;
            ma_row_d = {r12_q, r13_q};
        end
    end

    always_comb begin
        row_start = hcc_q == 8'd0 && rcc_q == 5'd0 && state_q == NORMAL;
        hdisp_now = hcc_q == r1_q ? 1'b0 : hcc_q == 8'd0 ? 1'b1 : hdisp_q;
        vdisp_now = (row_start && vcc_q == r6_q) ? 1'b0 : vdisp_q;
        hs_start  = hcc_q == r2_q && r3_q[3:0] != 4'd0 && hsw_q == 4'd0;
        hsw_d     = hs_start ? r3_q[3:0] - 4'd1 : hsw_q != 4'd0 ? hsw_q - 4'd1 : 4'd0;
        vs_start  = row_start && vcc_q == r7_q && !vs_q;
        vs_now    = vs_q || vs_start;
        vcnt_cur  = vs_start ? 4'd0 : vcnt_q;
        vs_d      = vs_now && !(line_end && vcnt_cur == r3_q[7:4] - 4'd1);
        vcnt_d    = (vs_now && line_end) ? vcnt_cur + 4'd1 : vcnt_cur;
        hdisp_d   = hdisp_now;
        vdisp_d   = frame_start ? 1'b1 : vdisp_now;
        hsync_d   = hs_start || hsw_q != 4'd0;
        vsync_d   = vs_now;
        de_d      = hdisp_now && vdisp_now;
        ma_d      = ma_row_q + 14'(hcc_q);
    end
endmodule
